// File: rtl/iq_window_integrator.sv
// iq_window_integrator: trigger-gated I/Q window integrator over five lanes per clock.
// Define DEMOD_INTEG_SAT_EN to get saturating accumulators and a live sat_flag;
// without it the accumulators wrap in two's complement and sat_flag stays 0.
module iq_window_integrator #(
    parameter int ACC_W = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk100,
    input  logic             reset_n,
    input  logic             trigger,
    input  logic [LEN_W-1:0] delay,
    input  logic [LEN_W-1:0] window_len,
    input  logic             data_valid,
    input  logic [15:0]      i_in_0,
    input  logic [15:0]      i_in_1,
    input  logic [15:0]      i_in_2,
    input  logic [15:0]      i_in_3,
    input  logic [15:0]      i_in_4,
    input  logic [15:0]      q_in_0,
    input  logic [15:0]      q_in_1,
    input  logic [15:0]      q_in_2,
    input  logic [15:0]      q_in_3,
    input  logic [15:0]      q_in_4,
    output logic             iq_valid,
    output logic [ACC_W-1:0] i_val,
    output logic [ACC_W-1:0] q_val,
    output logic             busy,
    output logic             sat_flag,
    output logic             missed_trig
);
    typedef enum logic [1:0] {IDLE, DELAY, INTEG, DONE} stateT;

    stateT            state, stateNxt;
    logic             trigQ, trigEdge, goDone;
    logic [LEN_W-1:0] delayCnt, delayCntNxt, lenReg, lenNxt, cnt, cntNxt, cntInc;
    logic [ACC_W-1:0] accI, accINxt, accQ, accQNxt;
    logic             satAcc, satNxt;
    logic [18:0]      laneI, laneQ;
    logic [ACC_W:0]   addI, addQ;

    function automatic logic [18:0] laneSum(input logic [15:0] a, b, c, d, e);
        return {{3{a[15]}}, a} + {{3{b[15]}}, b} + {{3{c[15]}}, c} + {{3{d[15]}}, d} + {{3{e[15]}}, e};
    endfunction

    // Result is {clipped, new accumulator value}.
`ifdef DEMOD_INTEG_SAT_EN
    function automatic logic [ACC_W:0] addLane(input logic [ACC_W-1:0] acc, input logic [18:0] lane);
        logic [ACC_W:0] s;
        s = {acc[ACC_W-1], acc} + {{(ACC_W-18){lane[18]}}, lane};
        return (s[ACC_W] == s[ACC_W-1]) ? {1'b0, s[ACC_W-1:0]}
                                        : {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    endfunction
`else
    function automatic logic [ACC_W:0] addLane(input logic [ACC_W-1:0] acc, input logic [18:0] lane);
        return {1'b0, acc + {{(ACC_W-19){lane[18]}}, lane}};
    endfunction
`endif

    assign laneI    = laneSum(i_in_0, i_in_1, i_in_2, i_in_3, i_in_4);
    assign laneQ    = laneSum(q_in_0, q_in_1, q_in_2, q_in_3, q_in_4);
    assign addI     = addLane(accI, laneI);
    assign addQ     = addLane(accQ, laneQ);
    assign trigEdge = trigger & ~trigQ;
    assign cntInc   = cnt + 1'b1;
    assign busy     = state != IDLE;
    assign goDone   = (stateNxt == DONE) && (state != DONE);

    // Next state, window counters and accumulators; stalled cycles leave everything untouched.
    always_comb begin
        stateNxt    = state;
        delayCntNxt = delayCnt;
        lenNxt      = lenReg;
        cntNxt      = cnt;
        accINxt     = accI;
        accQNxt     = accQ;
        satNxt      = satAcc;
        case (state)
            IDLE: if (trigEdge) begin
                delayCntNxt = delay;
                lenNxt      = window_len;
                cntNxt      = '0;
                accINxt     = '0;
                accQNxt     = '0;
                satNxt      = 1'b0;
                stateNxt    = (delay != '0) ? DELAY : (window_len == '0) ? DONE : INTEG;
            end
            DELAY: if (data_valid) begin
                delayCntNxt = delayCnt - 1'b1;
                if (delayCnt == LEN_W'(1)) stateNxt = (lenReg == '0) ? DONE : INTEG;
            end
            INTEG: if (lenReg == '0) begin
                stateNxt = DONE;
            end else if (data_valid) begin
                accINxt  = addI[ACC_W-1:0];
                accQNxt  = addQ[ACC_W-1:0];
                satNxt   = satAcc | addI[ACC_W] | addQ[ACC_W];
                cntNxt   = cntInc;
                stateNxt = (cntInc == lenReg) ? DONE : INTEG;
            end
            default: stateNxt = IDLE;
        endcase
    end

    // State and datapath registers; results are captured as the window closes so they show with iq_valid.
    always_ff @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            trigQ       <= 1'b0;
            delayCnt    <= '0;
            lenReg      <= '0;
            cnt         <= '0;
            accI        <= '0;
            accQ        <= '0;
            satAcc      <= 1'b0;
            iq_valid    <= 1'b0;
            i_val       <= '0;
            q_val       <= '0;
            sat_flag    <= 1'b0;
            missed_trig <= 1'b0;
        end else begin
            state    <= stateNxt;
            trigQ    <= trigger;
            delayCnt <= delayCntNxt;
            lenReg   <= lenNxt;
            cnt      <= cntNxt;
            accI     <= accINxt;
            accQ     <= accQNxt;
            satAcc   <= satNxt;
            iq_valid <= goDone;
            if (goDone) begin
                i_val    <= accINxt;
                q_val    <= accQNxt;
                sat_flag <= satNxt;
            end
            if (trigEdge && state != IDLE) missed_trig <= 1'b1;
        end
    end
endmodule

// File: tb/tb_iq_window_integrator.sv
// tb_iq_window_integrator: directed and random stimulus against a valid-cycle counting reference model.
module tb_iq_window_integrator;
    logic        clk100 = 1'b0, reset_n = 1'b1, trigger = 1'b0, data_valid = 1'b0;
    logic [15:0] delay = '0, window_len = '0;
    logic [15:0] iIn [5];
    logic [15:0] qIn [5];
    logic        iq_valid, busy, sat_flag, missed_trig;
    logic [31:0] i_val, q_val;
    int          checks = 0, passes = 0, cyc = 0, iqCnt = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    iq_window_integrator dut (
        .clk100(clk100), .reset_n(reset_n), .trigger(trigger), .delay(delay),
        .window_len(window_len), .data_valid(data_valid),
        .i_in_0(iIn[0]), .i_in_1(iIn[1]), .i_in_2(iIn[2]), .i_in_3(iIn[3]), .i_in_4(iIn[4]),
        .q_in_0(qIn[0]), .q_in_1(qIn[1]), .q_in_2(qIn[2]), .q_in_3(qIn[3]), .q_in_4(qIn[4]),
        .iq_valid(iq_valid), .i_val(i_val), .q_val(q_val), .busy(busy),
        .sat_flag(sat_flag), .missed_trig(missed_trig)
    );

    always #5 clk100 = ~clk100;
    always @(posedge clk100) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: a window skips `delay` valid cycles after the edge, sums the next
    // `window_len` valid cycles, and reports in the cycle after its last counted cycle.
    logic   tq = 1'b0;
    bit     active = 0, inDone = 0, clip = 0;
    int     skip = 0, take = 0;
    longint sI = 0, sQ = 0;
    bit     eIq = 0, eBusy = 0, eSat = 0, eMissed = 0;
    longint eI = 0, eQ = 0;

    function automatic longint accum(input longint a, input longint l);
        longint s;
        s = a + l;
`ifdef DEMOD_INTEG_SAT_EN
        if (s > MAXV) begin clip = 1; return MAXV; end
        if (s < MINV) begin clip = 1; return MINV; end
        return s;
`else
        return longint'(int'(s));
`endif
    endfunction

    always @(posedge clk100 or negedge reset_n) begin
        if (!reset_n) begin
            tq = 0; active = 0; inDone = 0;
            eIq = 0; eBusy = 0; eSat = 0; eMissed = 0; eI = 0; eQ = 0;
        end else begin
            bit     e;
            longint li, lq;
            e  = trigger & ~tq;
            tq = trigger;
            eIq = 0;
            li = 0;
            lq = 0;
            for (int k = 0; k < 5; k++) begin
                li += longint'($signed(iIn[k]));
                lq += longint'($signed(qIn[k]));
            end
            if (inDone) begin
                inDone = 0; active = 0;
                if (e) eMissed = 1;
            end else if (active) begin
                if (e) eMissed = 1;
                if (data_valid) begin
                    if (skip > 0) skip--;
                    else begin sI = accum(sI, li); sQ = accum(sQ, lq); take--; end
                end
                if (skip == 0 && take == 0) begin
                    inDone = 1; eIq = 1; eI = sI; eQ = sQ; eSat = clip;
                end
            end else if (e) begin
                active = 1; skip = int'(delay); take = int'(window_len);
                sI = 0; sQ = 0; clip = 0;
                if (skip == 0 && take == 0) begin
                    inDone = 1; eIq = 1; eI = 0; eQ = 0; eSat = 0;
                end
            end
            eBusy = active;
        end
    end

    // Every cycle, away from the clock edge, outputs must match the model.
    always @(negedge clk100) begin
        chk("iq_valid", longint'(iq_valid), longint'(eIq));
        chk("busy", longint'(busy), longint'(eBusy));
        chk("sat_flag", longint'(sat_flag), longint'(eSat));
        chk("missed_trig", longint'(missed_trig), longint'(eMissed));
        chk("i_val", longint'($signed(i_val)), eI);
        chk("q_val", longint'($signed(q_val)), eQ);
        if (iq_valid) iqCnt++;
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic lanes(input int i, input int q);
        for (int k = 0; k < 5; k++) begin
            iIn[k] = 16'(i);
            qIn[k] = 16'(q);
        end
    endtask

    task automatic fire(input int d, input int l, output int t);
        delay = 16'(d);
        window_len = 16'(l);
        trigger = 1'b1;
        t = cyc;
        tick();
        trigger = 1'b0;
    endtask

    task automatic waitIq(input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (iq_valid) begin at = cyc; break; end
        end
        if (at < 0) chk("iq_timeout", 0, 1);
    endtask

    initial begin
        int t, at, n0;
        lanes(0, 0);
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_iq_valid", longint'(iq_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_i_val", longint'(i_val), 0);
        chk("rst_missed", longint'(missed_trig), 0);
        reset_n = 1'b1;
        tick();
        // D=0, L=4, I=100, Q=-50
        data_valid = 1'b1;
        lanes(100, -50);
        fire(0, 4, t);
        waitIq(20, at);
        chk("t1_latency", longint'(at - t), 5);
        chk("t1_i_val", longint'($signed(i_val)), 2000);
        chk("t1_q_val", longint'($signed(q_val)), -1000);
        tick();
        chk("t1_busy_fall", longint'(busy), 0);
        // D=3, L=2 with a two-cycle stall inside the window
        lanes(1, 0);
        tick();
        fire(3, 2, t);
        tick();
        tick();
        tick();
        lanes(7, 0);
        tick();
        data_valid = 1'b0;
        lanes(99, 0);
        tick();
        tick();
        data_valid = 1'b1;
        lanes(7, 0);
        chk("t2_early", longint'(iq_valid), 0);
        tick();
        lanes(1, 0);
        chk("t2_iq_at_8", longint'(iq_valid), 1);
        chk("t2_i_val", longint'($signed(i_val)), 70);
        // D=2, L=0
        tick();
        fire(2, 0, t);
        tick();
        chk("t3_early", longint'(iq_valid), 0);
        tick();
        chk("t3_iq_at_3", longint'(iq_valid), 1);
        chk("t3_i_val", longint'($signed(i_val)), 0);
        chk("t3_q_val", longint'($signed(q_val)), 0);
        // retrigger two cycles into an L=10 window
        tick();
        lanes(3, -2);
        chk("t4_missed_pre", longint'(missed_trig), 0);
        n0 = iqCnt;
        fire(0, 10, t);
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        waitIq(30, at);
        chk("t4_latency", longint'(at - t), 11);
        chk("t4_missed", longint'(missed_trig), 1);
        chk("t4_i_val", longint'($signed(i_val)), 150);
        chk("t4_q_val", longint'($signed(q_val)), -100);
        repeat (15) tick();
        chk("t4_single_iq", longint'(iqCnt - n0), 1);
        // full-length window at full scale
        lanes(32767, -32768);
        fire(0, 65535, t);
        waitIq(70000, at);
        chk("t5_latency", longint'(at - t), 65536);
`ifdef DEMOD_INTEG_SAT_EN
        chk("t5_i_val", longint'($signed(i_val)), 2147483647);
        chk("t5_sat_flag", longint'(sat_flag), 1);
`else
        chk("t5_i_val", longint'($signed(i_val)), 2146992133);
        chk("t5_sat_flag", longint'(sat_flag), 0);
`endif
        // asynchronous reset mid-window, then a fresh window
        tick();
        lanes(5, -5);
        fire(0, 20, t);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        chk("t6_rst_i_val", longint'(i_val), 0);
        chk("t6_rst_busy", longint'(busy), 0);
        chk("t6_rst_missed", longint'(missed_trig), 0);
        chk("t6_rst_sat", longint'(sat_flag), 0);
        tick();
        tick();
        reset_n = 1'b1;
        n0 = iqCnt;
        repeat (25) tick();
        chk("t6_no_iq", longint'(iqCnt - n0), 0);
        fire(1, 3, t);
        waitIq(10, at);
        chk("t6_latency", longint'(at - t), 5);
        chk("t6_i_val", longint'($signed(i_val)), 75);
        chk("t6_q_val", longint'($signed(q_val)), -75);
        // random traffic: triggers, stalls, short windows, full-range samples
        repeat (3000) begin
            tick();
            trigger    = $urandom_range(0, 5) == 0;
            data_valid = $urandom_range(0, 3) != 0;
            delay      = 16'($urandom_range(0, 4));
            window_len = 16'($urandom_range(0, 6));
            for (int k = 0; k < 5; k++) begin
                iIn[k] = 16'($urandom);
                qIn[k] = 16'($urandom);
            end
        end
        tick();
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
